// File: rtl/fmap_buf_pkg.sv
// fmap_buf_pkg: shared defaults, bank-state enum and address-width helper for the ping-pong feature-map buffer.
package fmap_buf_pkg;
  localparam int CH_DEF = 4;
  localparam int DW_DEF = 21;
  localparam int DEPTH_DEF = 32;
  typedef enum logic {BANK_EMPTY, BANK_FULL} bank_st_e;
  function automatic int aw_of(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/fmap_bank_ram.sv
// fmap_bank_ram: one simple-dual-port bank with sync write and per-channel registered reads.
module fmap_bank_ram #(
  parameter int CH = 4,
  parameter int DW = 21,
  parameter int DEPTH = 32,
  parameter int AW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [CH*DW-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  input  logic [CH-1:0]    rden_i,
  output logic [CH*DW-1:0] rdata_o
);
  logic [CH*DW-1:0] mem_q [DEPTH];
  logic [CH*DW-1:0] rdata_q;
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  always_ff @(posedge clk)
    if (rst) rdata_q <= '0;
    else
      for (int c = 0; c < CH; c++)
        if (rden_i[c]) rdata_q[c*DW +: DW] <= mem_q[raddr_i][c*DW +: DW];
  assign rdata_o = rdata_q;
endmodule

// File: rtl/fmap_pingpong_buf.sv
// fmap_pingpong_buf: two-bank ping-pong feature-map buffer; writes fill one bank while the other is read.
// Optional macro FMAP_BUF_OVERFLOW_CHK_EN enables the sticky overflow flag.
module fmap_pingpong_buf
  import fmap_buf_pkg::*;
#(
  parameter int CH = CH_DEF,
  parameter int DW = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW = aw_of(DEPTH)
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             start_wr,
  input  logic             de_in,
  input  logic [CH*DW-1:0] in,
  input  logic [AW-1:0]    rd_addr,
  input  logic [CH-1:0]    rden,
  input  logic             rd_done,
  output logic [CH*DW-1:0] q,
  output logic             de_out,
  output logic             wr_ready,
  output logic             rd_ready,
  output logic             overflow
);
  bank_st_e st_q [2];
  bank_st_e st_d [2];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d, de_out_q;
  logic [CH-1:0] sel_q, sel_d;
  logic acc, last, rel;
  logic [CH*DW-1:0] r0, r1;
  assign wr_ready = st_q[wr_bank_q] == BANK_EMPTY;
  assign rd_ready = st_q[rd_bank_q] == BANK_FULL;
  // completion targets an EMPTY bank and release a FULL one, so both can land in one cycle
  always_comb begin
    acc = de_in & start_wr & wr_ready;
    last = acc & (wr_ptr_q == AW'(DEPTH - 1));
    rel = rd_done & rd_ready;
    st_d = st_q;
    if (last) st_d[wr_bank_q] = BANK_FULL;
    if (rel) st_d[rd_bank_q] = BANK_EMPTY;
    wr_ptr_d = last ? '0 : wr_ptr_q + AW'(acc);
    wr_bank_d = wr_bank_q ^ last;
    rd_bank_d = rd_bank_q ^ rel;
    sel_d = (sel_q & ~rden) | (rden & {CH{rd_bank_q}});
  end
  always_ff @(posedge clk)
    if (RESET) begin
      st_q[0] <= BANK_EMPTY;
      st_q[1] <= BANK_EMPTY;
      wr_ptr_q <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      sel_q <= '0;
      de_out_q <= 1'b0;
    end else begin
      st_q <= st_d;
      wr_ptr_q <= wr_ptr_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      sel_q <= sel_d;
      de_out_q <= |rden;
    end
  fmap_bank_ram #(.CH(CH), .DW(DW), .DEPTH(DEPTH), .AW(AW)) u_bank0 (
    .clk(clk), .rst(RESET), .we_i(acc & ~wr_bank_q), .waddr_i(wr_ptr_q), .wdata_i(in),
    .raddr_i(rd_addr), .rden_i(rden & {CH{~rd_bank_q}}), .rdata_o(r0)
  );
  fmap_bank_ram #(.CH(CH), .DW(DW), .DEPTH(DEPTH), .AW(AW)) u_bank1 (
    .clk(clk), .rst(RESET), .we_i(acc & wr_bank_q), .waddr_i(wr_ptr_q), .wdata_i(in),
    .raddr_i(rd_addr), .rden_i(rden & {CH{rd_bank_q}}), .rdata_o(r1)
  );
  // each channel remembers which bank last loaded it, so unread channels hold across bank swaps
  for (genvar c = 0; c < CH; c++) begin : g_q
    assign q[c*DW +: DW] = sel_q[c] ? r1[c*DW +: DW] : r0[c*DW +: DW];
  end
  assign de_out = de_out_q;
`ifdef FMAP_BUF_OVERFLOW_CHK_EN
  logic ovf_q;
  always_ff @(posedge clk)
    if (RESET) ovf_q <= 1'b0;
    else if (de_in & start_wr & ~wr_ready) ovf_q <= 1'b1;
  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif
endmodule
